alu_sequencer: RTL

Sequences the team's 2-operand ALU (add/sub/and/or, N-bit, combinational result plus an add-carry status bit) from a single shared data-entry path, calculator-style. The operator enters OP1, then OP2, then OpCode, each confirmed with `enter`. The block holds the operands and opcode in registers that drive the ALU and captures the ALU's result and status. It selects the value shown on the display and supports undo, clear and result chaining.

---
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Calculator-style sequencer for the shared 2-operand ALU: collects op1, op2 and opcode
// from one entry path, captures the ALU result and drives the display selection.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// WAIT_OP1    | echo data_in, enter loads op1
// WAIT_OP2    | echo data_in, enter loads op2
// WAIT_OPCODE | show op2, enter loads opcode
// CALC        | operands stable for one cycle, buttons ignored, capture result
// SHOW_RESULT | show result, enter chains result into op1
module alu_sequencer #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic [1:0]   opcode_in,
    input  logic         enter,
    input  logic         undo,
    input  logic         clear,
    output logic [N-1:0] alu_op1,
    output logic [N-1:0] alu_op2,
    output logic [1:0]   alu_opcode,
    input  logic [N-1:0] alu_result,
    input  logic         alu_status,
    output logic [N-1:0] display_value,
    output logic [2:0]   state_out,
    output logic         result_valid,
    output logic         overflow
);

    localparam logic [2:0] S_WAIT_OP1    = 3'b000;
    localparam logic [2:0] S_WAIT_OP2    = 3'b001;
    localparam logic [2:0] S_WAIT_OPCODE = 3'b010;
    localparam logic [2:0] S_CALC        = 3'b011;
    localparam logic [2:0] S_SHOW_RESULT = 3'b100;

    logic [2:0]   state;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic [1:0]   opcode;
    logic [N-1:0] result_reg;
    logic         ovf_reg;

    logic enter_d;
    logic undo_d;
    logic clear_d;
    logic enter_rise;
    logic undo_rise;
    logic clear_rise;

    // Delayed copies reset high so a button held through reset release never fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_d <= 1'b1;
            undo_d  <= 1'b1;
            clear_d <= 1'b1;
        end else begin
            enter_d <= enter;
            undo_d  <= undo;
            clear_d <= clear;
        end
    end

    assign enter_rise = enter & ~enter_d;
    assign undo_rise  = undo  & ~undo_d;
    assign clear_rise = clear & ~clear_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_WAIT_OP1;
            op1        <= '0;
            op2        <= '0;
            opcode     <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else if (state == S_CALC) begin
            // Button edges seen here are dropped, not deferred.
            result_reg <= alu_result;
            ovf_reg    <= alu_status;
            state      <= S_SHOW_RESULT;
        end else if (clear_rise) begin
            op1        <= '0;
            op2        <= '0;
            opcode     <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            state      <= S_WAIT_OP1;
        end else if (undo_rise) begin
            case (state)
                S_WAIT_OP2:    state <= S_WAIT_OP1;
                S_WAIT_OPCODE: state <= S_WAIT_OP2;
                S_SHOW_RESULT: state <= S_WAIT_OPCODE;
                S_WAIT_OP1:    state <= S_WAIT_OP1;
                default:       state <= S_WAIT_OP1;
            endcase
        end else if (enter_rise) begin
            case (state)
                S_WAIT_OP1: begin
                    op1   <= data_in;
                    state <= S_WAIT_OP2;
                end
                S_WAIT_OP2: begin
                    op2   <= data_in;
                    state <= S_WAIT_OPCODE;
                end
                S_WAIT_OPCODE: begin
                    opcode <= opcode_in;
                    state  <= S_CALC;
                end
                S_SHOW_RESULT: begin
                    op1     <= result_reg;
                    op2     <= '0;
                    ovf_reg <= 1'b0;
                    state   <= S_WAIT_OP2;
                end
                default: state <= S_WAIT_OP1;
            endcase
        end else if (state > S_SHOW_RESULT) begin
            state <= S_WAIT_OP1;
        end
    end

    always_comb begin
        display_value = data_in;
        case (state)
            S_WAIT_OP1, S_WAIT_OP2:  display_value = data_in;
            S_WAIT_OPCODE, S_CALC:   display_value = op2;
            S_SHOW_RESULT:           display_value = result_reg;
            default:                 display_value = data_in;
        endcase
    end

    assign alu_op1      = op1;
    assign alu_op2      = op2;
    assign alu_opcode   = opcode;
    assign state_out    = state;
    assign result_valid = (state == S_SHOW_RESULT);
    assign overflow     = result_valid & ovf_reg;

endmodule
